// File: rtl/educell_spikeprop.sv
// Spike-propagation decoding cell.
// A syndrome cell emits a spike burst in all six directions and waits for a
// matching spike to come back; a non-syndrome cell relays the first arriving
// spike straight through to the opposite side.
// Optional feature: define EDU_SPIKE_TIMEOUT_EN to bound WAIT/LISTEN with a
// CNT_W-bit counter that ends the round with timeout=1 after MAX_WAIT.
module educell_spikeprop #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned MAX_WAIT = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear,
  input  logic       syndrome,
  input  logic [5:0] syndir,
  output logic       spike_out_nw,
  output logic       spike_out_ne,
  output logic       spike_out_sw,
  output logic       spike_out_se,
  output logic       spike_out_n,
  output logic       spike_out_s,
  output logic       busy,
  output logic       corr_valid,
  input  logic       corr_ready,
  output logic [5:0] corr_dir,
  output logic       timeout
);

  if (MAX_WAIT >= (1 << CNT_W)) begin : g_bad_param
    $error("MAX_WAIT must be below 2**CNT_W");
  end

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StWait,
    StListen,
    StRelay,
    StReport,
    StDone
  } state_e;

  state_e     state_q, state_d;
  // Direction vectors share one bit order: [0]=s [1]=n [2]=se [3]=sw [4]=ne [5]=nw
  logic [5:0] spike_q, spike_d;
  logic [5:0] corr_dir_q, corr_dir_d;
  logic       busy_q, busy_d;
  logic       corr_valid_q, corr_valid_d;
  logic       hit;
  logic [5:0] sel_dir;
  logic [5:0] opp_dir;

  // Isolate the lowest set bit so a malformed multi-hot arrival resolves deterministically
  assign sel_dir = syndir & (~syndir + 6'd1);
  assign hit     = |syndir;
  // Relay goes out the side facing away from the arrival
  assign opp_dir = {sel_dir[2], sel_dir[3], sel_dir[4], sel_dir[5], sel_dir[0], sel_dir[1]};

`ifdef EDU_SPIKE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(MAX_WAIT));
`endif

  // Next-state, next-output and counter logic
  always_comb begin
    state_d    = state_q;
    spike_d    = '0;
    corr_dir_d = corr_dir_q;
`ifdef EDU_SPIKE_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (syndrome) begin
            state_d = StEmit;
            spike_d = '1;
          end else begin
            state_d = StListen;
`ifdef EDU_SPIKE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StEmit: begin
        state_d = StWait;
`ifdef EDU_SPIKE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // A spike arriving on the expiry edge still counts as a match
        if (hit) begin
          corr_dir_d = sel_dir;
          state_d    = StReport;
        end
`ifdef EDU_SPIKE_TIMEOUT_EN
        else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StListen: begin
        if (hit) begin
          spike_d    = opp_dir;
          corr_dir_d = sel_dir;
          state_d    = StRelay;
        end
`ifdef EDU_SPIKE_TIMEOUT_EN
        else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StRelay: begin
        state_d = StRelay;
      end
      StReport: begin
        if (corr_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a coincident start
    if (clear) begin
      state_d    = StIdle;
      spike_d    = '0;
      corr_dir_d = '0;
`ifdef EDU_SPIKE_TIMEOUT_EN
      cnt_d      = '0;
      timeout_d  = 1'b0;
`endif
    end

    busy_d       = (state_d == StEmit) || (state_d == StWait) ||
                   (state_d == StListen) || (state_d == StReport);
    corr_valid_d = (state_d == StReport);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      spike_q      <= '0;
      corr_dir_q   <= '0;
      busy_q       <= 1'b0;
      corr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      spike_q      <= spike_d;
      corr_dir_q   <= corr_dir_d;
      busy_q       <= busy_d;
      corr_valid_q <= corr_valid_d;
    end
  end

`ifdef EDU_SPIKE_TIMEOUT_EN
  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign spike_out_s  = spike_q[0];
  assign spike_out_n  = spike_q[1];
  assign spike_out_se = spike_q[2];
  assign spike_out_sw = spike_q[3];
  assign spike_out_ne = spike_q[4];
  assign spike_out_nw = spike_q[5];
  assign busy         = busy_q;
  assign corr_valid   = corr_valid_q;
  assign corr_dir     = corr_dir_q;

endmodule

// File: tb/tb_educell_spikeprop.sv
// Scoreboard bench for educell_spikeprop: stimulus tasks push expected spikes,
// reports and timeouts; a negedge monitor pops and compares them.
module tb_educell_spikeprop;

  localparam int unsigned TbCntW    = 6;
  localparam int unsigned TbMaxWait = 3;
`ifdef EDU_SPIKE_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       syndrome;
  logic [5:0] syndir;
  logic       corr_ready;
  logic       spike_out_nw, spike_out_ne, spike_out_sw;
  logic       spike_out_se, spike_out_n, spike_out_s;
  logic       busy, corr_valid, timeout;
  logic [5:0] corr_dir;
  logic [5:0] spk_vec;

  int         checks;
  int         failures;
  logic [5:0] exp_spk[$];
  logic [5:0] exp_rep[$];
  int         exp_to;
  logic       timeout_prev;

  educell_spikeprop #(
    .CNT_W   (TbCntW),
    .MAX_WAIT(TbMaxWait)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .syndrome    (syndrome),
    .syndir      (syndir),
    .spike_out_nw(spike_out_nw),
    .spike_out_ne(spike_out_ne),
    .spike_out_sw(spike_out_sw),
    .spike_out_se(spike_out_se),
    .spike_out_n (spike_out_n),
    .spike_out_s (spike_out_s),
    .busy        (busy),
    .corr_valid  (corr_valid),
    .corr_ready  (corr_ready),
    .corr_dir    (corr_dir),
    .timeout     (timeout)
  );

  assign spk_vec = {spike_out_nw, spike_out_ne, spike_out_sw, spike_out_se, spike_out_n,
                    spike_out_s};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arrival direction actually honoured: the lowest-numbered set bit
  function automatic logic [5:0] lowbit(input logic [5:0] v);
    logic [5:0] one;
    one = 6'd1;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) return one << i;
    end
    return '0;
  endfunction

  // s<->n, se<->nw, sw<->ne
  function automatic logic [5:0] opposite(input logic [5:0] v);
    int         opp_idx[6];
    logic [5:0] one;
    opp_idx = '{1, 0, 5, 4, 3, 2};
    one     = 6'd1;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) return one << opp_idx[i];
    end
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_dir", corr_dir, 0);
    check("clr_timeout", timeout, 0);
    check("clr_valid", corr_valid, 0);
  endtask

  // Syndrome round: matching spike arrives d cycles after WAIT's first sample
  task automatic run_root(input int d, input logic [5:0] dir, input int r);
    bit timed_out;
    timed_out = TimeoutEn && (d > int'(TbMaxWait));
    exp_spk.push_back(6'h3f);
    if (timed_out) exp_to++;
    else exp_rep.push_back(lowbit(dir));
    start    = 1'b1;
    syndrome = 1'b1;
    tick();
    start    = 1'b0;
    syndrome = 1'b0;
    check("emit_spikes", spk_vec, 6'h3f);
    check("emit_busy", busy, 1);
    tick();
    check("wait_spikes", spk_vec, 0);
    check("wait_busy", busy, 1);
    for (int i = 0; i < d; i++) tick();
    syndir = dir;
    tick();
    syndir = '0;
    check("report_valid", corr_valid, timed_out ? 0 : 1);
    for (int i = 0; i < r; i++) tick();
    corr_ready = 1'b1;
    tick();
    corr_ready = 1'b0;
    check("done_busy", busy, 0);
    check("done_valid", corr_valid, 0);
    check("done_dir", corr_dir, timed_out ? 6'h00 : lowbit(dir));
    check("done_timeout", timeout, timed_out ? 1 : 0);
    tick();
    check("done_hold_dir", corr_dir, timed_out ? 6'h00 : lowbit(dir));
    do_clear();
  endtask

  // Non-syndrome round: first arrival after d idle cycles, then a second ignored one
  task automatic run_listen(input int d, input logic [5:0] dir, input logic [5:0] dir2);
    bit timed_out;
    timed_out = TimeoutEn && (d > int'(TbMaxWait));
    if (timed_out) exp_to++;
    else exp_spk.push_back(opposite(dir));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("listen_busy", busy, timed_out && d == 0 ? 0 : 1);
    for (int i = 0; i < d; i++) tick();
    syndir = dir;
    tick();
    syndir = '0;
    check("relay_spike", spk_vec, timed_out ? 6'h00 : opposite(dir));
    check("relay_busy", busy, 0);
    check("relay_dir", corr_dir, timed_out ? 6'h00 : lowbit(dir));
    tick();
    check("relay_spike_gone", spk_vec, 0);
    syndir   = dir2;
    start    = 1'b1;
    syndrome = 1'b1;
    tick();
    syndir   = '0;
    start    = 1'b0;
    syndrome = 1'b0;
    tick();
    check("relay_no_valid", corr_valid, 0);
    check("relay_no_spike", spk_vec, 0);
    check("relay_timeout", timeout, timed_out ? 1 : 0);
    do_clear();
  endtask

`ifdef EDU_SPIKE_TIMEOUT_EN
  // Timeout must appear exactly MAX_WAIT+1 cycles after WAIT is entered
  task automatic run_timeout_directed();
    exp_spk.push_back(6'h3f);
    exp_to++;
    start    = 1'b1;
    syndrome = 1'b1;
    tick();
    start    = 1'b0;
    syndrome = 1'b0;
    tick();
    for (int i = 0; i < int'(TbMaxWait); i++) begin
      tick();
      check("to_early", timeout, 0);
    end
    tick();
    check("to_fire", timeout, 1);
    check("to_busy", busy, 0);
    do_clear();
  endtask
`endif

  // Monitor: every visible spike/report/timeout must match a queued expectation
  initial begin
    timeout_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        timeout_prev = 1'b0;
      end else begin
        if (spk_vec != 6'h00) begin
          if (exp_spk.size() == 0) check("spike_unexpected", spk_vec, 0);
          else check("spike", spk_vec, exp_spk.pop_front());
        end
        if (corr_valid) begin
          if (exp_rep.size() == 0) begin
            check("report_unexpected", corr_valid, 0);
          end else begin
            check("report_dir", corr_dir, exp_rep[0]);
            if (corr_ready) void'(exp_rep.pop_front());
          end
        end
        if (timeout && !timeout_prev) begin
          check("timeout_expected", (exp_to > 0) ? 1 : 0, 1);
          if (exp_to > 0) exp_to--;
        end
        timeout_prev = timeout;
      end
    end
  end

  initial begin
    logic [5:0] rdir;
    checks     = 0;
    failures   = 0;
    exp_to     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    syndrome   = 1'b0;
    syndir     = '0;
    corr_ready = 1'b0;
    #2;
    check("rst_spikes", spk_vec, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", corr_valid, 0);
    check("rst_dir", corr_dir, 0);
    check("rst_timeout", timeout, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_root(3, 6'b000100, 3);
    run_listen(2, 6'b010000, 6'b000001);
    run_listen(0, 6'b101100, 6'b000010);
`ifdef EDU_SPIKE_TIMEOUT_EN
    run_timeout_directed();
`endif

    // start with clear in the same cycle stays idle
    start    = 1'b1;
    clear    = 1'b1;
    syndrome = 1'b1;
    tick();
    start    = 1'b0;
    clear    = 1'b0;
    syndrome = 1'b0;
    check("startclr_busy", busy, 0);
    check("startclr_spikes", spk_vec, 0);
    tick();
    check("startclr_idle", busy, 0);

    // Reset asserted mid-cycle while reporting
    exp_spk.push_back(6'h3f);
    exp_rep.push_back(6'b000010);
    start    = 1'b1;
    syndrome = 1'b1;
    tick();
    start    = 1'b0;
    syndrome = 1'b0;
    tick();
    syndir = 6'b000010;
    tick();
    syndir = '0;
    check("pre_rst_valid", corr_valid, 1);
    #2;
    exp_rep.delete();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", corr_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_dir", corr_dir, 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", corr_valid, 0);

    for (int n = 0; n < 30; n++) begin
      rdir = 6'($urandom_range(1, 63));
      if ($urandom_range(0, 1) == 1) begin
        run_root(int'($urandom_range(0, 6)), rdir, int'($urandom_range(0, 3)));
      end else begin
        run_listen(int'($urandom_range(0, 6)), rdir, 6'($urandom_range(0, 63)));
      end
    end

    tick();
    check("spike_queue_left", exp_spk.size(), 0);
    check("report_queue_left", exp_rep.size(), 0);
    check("timeout_left", exp_to, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
